// File: rtl/ttl_259_pkg.sv
// Shared types and helpers for the 74F259 addressable latch and its serial loader.
// Holds the pin-mode decode and the sequencer state encoding.
package ttl_259_pkg;

  localparam int NBITS = 8;
  localparam int IDXW  = 3;

  typedef enum logic [1:0] {
    MODE_LATCH,
    MODE_MEMORY,
    MODE_DEMUX,
    MODE_CLEAR
  } mode_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } seq_state_t;

  function automatic mode_t decode_mode(input logic clr_n, input logic g_n);
    mode_t m;
    case ({clr_n, g_n})
      2'b10:   m = MODE_LATCH;
      2'b11:   m = MODE_MEMORY;
      2'b00:   m = MODE_DEMUX;
      default: m = MODE_CLEAR;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ttl_259_core.sv
// Eight-bit latch register with a single write port: clear, one-bit write,
// or one-bit write with all other bits zeroed (demux).
module ttl_259_core
  import ttl_259_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_we,
  input  logic [IDXW-1:0]  i_idx,
  input  logic             i_bit,
  input  logic             i_clr,
  input  logic             i_demux,
  output logic [NBITS-1:0] o_q
);

  logic [NBITS-1:0] r_q;
  logic [NBITS-1:0] w_next;

  // Clear dominates; the addressed bit takes the data; demux zeroes the rest.
  for (genvar gi = 0; gi < NBITS; gi++) begin : g_bit
    assign w_next[gi] = i_clr                                ? 1'b0 :
                        (i_we && (i_idx == IDXW'(gi)))       ? i_bit :
                        (i_we && i_demux)                    ? 1'b0 :
                                                               r_q[gi];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_q <= '0;
    end else begin
      r_q <= w_next;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ttl_74f259_loader.sv
// 74F259 addressable latch with a serial valid/ready loader that fills all
// eight latches; the sequencer arbitrates the core's single write port.
module ttl_74f259_loader
  import ttl_259_pkg::*;
#(
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             D,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             G_n,
  input  logic             CLR_n,
  output logic [NBITS-1:0] Q,
  input  logic             load_start,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             ser_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [IDXW-1:0] IDX_START = (LSB_FIRST != 0) ? 3'd0 : 3'd7;
  localparam logic [IDXW-1:0] IDX_LAST  = (LSB_FIRST != 0) ? 3'd7 : 3'd0;

  seq_state_t      r_state;
  logic [IDXW-1:0] r_index;
  logic            r_ready;
  logic            r_busy;
  logic            r_done;

  mode_t           w_mode;
  logic            w_clear;
  logic            w_accept;
  logic            w_we;
  logic [IDXW-1:0] w_idx;
  logic            w_bit;
  logic            w_demux;

  assign w_mode   = decode_mode(CLR_n, G_n);
  assign w_clear  = (w_mode == MODE_CLEAR);
  assign w_accept = (r_state == SHIFT) && ser_valid && !w_clear;

  // Clear reaches the core in every state; other pin modes only while idle.
  always_comb begin
    w_we    = 1'b0;
    w_idx   = {A, B, C};
    w_bit   = D;
    w_demux = 1'b0;
    case (r_state)
      IDLE: begin
        w_we    = (w_mode == MODE_LATCH) || (w_mode == MODE_DEMUX);
        w_demux = (w_mode == MODE_DEMUX);
      end
      SHIFT: begin
        w_we  = w_accept;
        w_idx = r_index;
        w_bit = ser_in;
      end
      default: ;
    endcase
  end

  ttl_259_core u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .i_we    (w_we),
    .i_idx   (w_idx),
    .i_bit   (w_bit),
    .i_clr   (w_clear),
    .i_demux (w_demux),
    .o_q     (Q)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_index <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (load_start && !w_clear) begin
            r_state <= SHIFT;
            r_index <= IDX_START;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (w_clear) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_accept) begin
            if (r_index == IDX_LAST) begin
              r_state <= DONE;
              r_ready <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_index <= (LSB_FIRST != 0) ? r_index + 3'd1 : r_index - 3'd1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ser_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_ttl_74f259_loader.sv
// Bench for the 74F259 loader: LSB-first and MSB-first instances share stimulus
// and are compared against a bit-count based reference model.
module tb_ttl_74f259_loader;

  logic clk = 1'b0;
  logic reset_n, d, a, b, c, g_n, clr_n, load_start, ser_in, ser_valid;
  logic [1:0][7:0] q_w;
  logic [1:0] rdy_w, busy_w, done_w;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_q[2];
  bit         m_load[2];
  int         m_cnt[2];
  bit         m_donep[2];

  always #5 clk = ~clk;

  ttl_74f259_loader #(.LSB_FIRST(1)) u_lsb (
    .clk(clk), .reset_n(reset_n), .D(d), .A(a), .B(b), .C(c), .G_n(g_n), .CLR_n(clr_n),
    .Q(q_w[0]), .load_start(load_start), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_ready(rdy_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  ttl_74f259_loader #(.LSB_FIRST(0)) u_msb (
    .clk(clk), .reset_n(reset_n), .D(d), .A(a), .B(b), .C(c), .G_n(g_n), .CLR_n(clr_n),
    .Q(q_w[1]), .load_start(load_start), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_ready(rdy_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  function automatic logic [10:0] dut_vec(int i);
    return {q_w[i], busy_w[i], rdy_w[i], done_w[i]};
  endfunction

  function automatic logic [10:0] exp_vec(int i);
    return {m_q[i], m_load[i] | m_donep[i], m_load[i], m_donep[i]};
  endfunction

  // Reference: a load is "bits accepted so far"; position derives from the count.
  task automatic model_step();
    bit clr_mode;
    logic [2:0] sel;
    int pos;
    clr_mode = !clr_n && g_n;
    sel = {a, b, c};
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        m_q[i] = 8'h00; m_load[i] = 0; m_cnt[i] = 0; m_donep[i] = 0;
      end else if (m_donep[i]) begin
        m_donep[i] = 0;
        if (clr_mode) m_q[i] = 8'h00;
      end else if (m_load[i]) begin
        if (clr_mode) begin
          m_q[i] = 8'h00; m_load[i] = 0;
        end else if (ser_valid) begin
          pos = (i == 0) ? m_cnt[i] : 7 - m_cnt[i];
          m_q[i][pos] = ser_in;
          m_cnt[i]++;
          if (m_cnt[i] == 8) begin
            m_load[i] = 0; m_donep[i] = 1;
          end
        end
      end else begin
        if (clr_mode) m_q[i] = 8'h00;
        else if (!clr_n) m_q[i] = 8'(d) << sel;
        else if (!g_n) m_q[i][sel] = d;
        if (load_start && !clr_mode) begin
          m_load[i] = 1; m_cnt[i] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic pins_idle();
    reset_n = 1; clr_n = 1; g_n = 1; load_start = 0;
    ser_valid = 0; ser_in = 0; d = 0; {a, b, c} = 3'd0;
  endtask

  task automatic test_reset();
    pins_idle();
    reset_n = 0; clr_n = 1'($urandom); g_n = 1'($urandom); d = 1'($urandom);
    load_start = 1; ser_valid = 1; {a, b, c} = 3'($urandom);
    tick();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (dut_vec(i) !== 11'h000) begin
        n_errors++;
        $display("FAIL reset inst%0d: got %h exp %h", i, dut_vec(i), 11'h000);
      end
    end
    pins_idle();
  endtask

  task automatic test_latch_memory();
    pins_idle();
    g_n = 0; d = 1; {a, b, c} = 3'b101;
    tick();
    {a, b, c} = 3'b010;
    tick();
    g_n = 1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (q_w[i] !== 8'h24 || dut_vec(i) !== exp_vec(i)) begin
          n_errors++;
          $display("FAIL latch_hold inst%0d step%0d: got %h exp %h", i, k, dut_vec(i), {8'h24, 3'b000});
        end
      end
      d = 1'($urandom); {a, b, c} = 3'($urandom);
      tick();
    end
    pins_idle();
  endtask

  task automatic fill_ones();
    clr_n = 1; g_n = 0; d = 1;
    for (int s = 0; s < 8; s++) begin
      {a, b, c} = 3'(s);
      tick();
    end
    g_n = 1;
  endtask

  task automatic test_demux_clear();
    pins_idle();
    fill_ones();
    clr_n = 0; g_n = 0; d = 1; {a, b, c} = 3'd3;
    tick();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (q_w[i] !== 8'h08 || dut_vec(i) !== exp_vec(i)) begin
        n_errors++;
        $display("FAIL demux inst%0d: got %h exp %h", i, q_w[i], 8'h08);
      end
    end
    g_n = 1;
    tick();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (q_w[i] !== 8'h00 || dut_vec(i) !== exp_vec(i)) begin
        n_errors++;
        $display("FAIL clear inst%0d: got %h exp %h", i, q_w[i], 8'h00);
      end
    end
    pins_idle();
  endtask

  task automatic test_serial();
    logic [7:0] bits;
    bits = 8'b0100_1101;  // bits[k] is the k-th serial bit: 1,0,1,1,0,0,1,0
    pins_idle();
    load_start = 1;
    tick();
    load_start = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        ser_valid = 0;
        for (int s = 0; s < 2; s++) begin
          tick();
          for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (rdy_w[i] !== 1'b1 || dut_vec(i) !== exp_vec(i)) begin
              n_errors++;
              $display("FAIL serial_stall inst%0d: got %h exp %h", i, dut_vec(i), exp_vec(i));
            end
          end
        end
      end
      ser_valid = 1; ser_in = bits[k];
      tick();
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (dut_vec(i) !== exp_vec(i)) begin
          n_errors++;
          $display("FAIL serial_bit%0d inst%0d: got %h exp %h", k, i, dut_vec(i), exp_vec(i));
        end
      end
    end
    ser_valid = 0;
    n_checks++;
    if (q_w[0] !== 8'h4D || q_w[1] !== 8'hB2 || done_w !== 2'b11 || busy_w !== 2'b11) begin
      n_errors++;
      $display("FAIL serial_final: got q %h/%h done %b busy %b exp 4d/b2 11 11", q_w[0], q_w[1], done_w, busy_w);
    end
    tick();
    n_checks++;
    if (done_w !== 2'b00 || busy_w !== 2'b00 || rdy_w !== 2'b00 || q_w[0] !== 8'h4D || q_w[1] !== 8'hB2) begin
      n_errors++;
      $display("FAIL serial_after: got done %b busy %b rdy %b exp 00 00 00", done_w, busy_w, rdy_w);
    end
    pins_idle();
  endtask

  task automatic test_abort();
    pins_idle();
    fill_ones();
    load_start = 1;
    tick();
    load_start = 0;
    ser_valid = 1; ser_in = 0;
    for (int k = 0; k < 3; k++) tick();
    ser_valid = 0;
    load_start = 1;  // ignored while busy
    tick();
    load_start = 0;
    g_n = 0; clr_n = 1; d = 0; {a, b, c} = 3'd7;  // latch write ignored in SHIFT
    tick();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (q_w[i] !== (i == 0 ? 8'hF8 : 8'h1F) || dut_vec(i) !== exp_vec(i)) begin
        n_errors++;
        $display("FAIL abort_partial inst%0d: got %h exp %h", i, dut_vec(i), exp_vec(i));
      end
    end
    clr_n = 0; g_n = 1;
    tick();
    clr_n = 1;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (dut_vec(i) !== 11'h000 || dut_vec(i) !== exp_vec(i)) begin
          n_errors++;
          $display("FAIL abort inst%0d step%0d: got %h exp %h", i, s, dut_vec(i), 11'h000);
        end
      end
      tick();
    end
    pins_idle();
  endtask

  task automatic test_random();
    pins_idle();
    for (int k = 0; k < 600; k++) begin
      reset_n    = ($urandom_range(0, 59) != 0);
      clr_n      = ($urandom_range(0, 11) != 0);
      g_n        = 1'($urandom);
      d          = 1'($urandom);
      {a, b, c}  = 3'($urandom);
      load_start = ($urandom_range(0, 5) == 0);
      ser_valid  = ($urandom_range(0, 3) != 0);
      ser_in     = 1'($urandom);
      tick();
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (dut_vec(i) !== exp_vec(i)) begin
          n_errors++;
          $display("FAIL random cyc%0d inst%0d: got %h exp %h", k, i, dut_vec(i), exp_vec(i));
        end
      end
    end
    pins_idle();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_q[i] = 8'h00; m_load[i] = 0; m_cnt[i] = 0; m_donep[i] = 0;
    end
    pins_idle();
    test_reset();
    test_latch_memory();
    test_demux_clear();
    test_serial();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
